// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: first-word-fall-through queue between fetch and decode.
// Holds DEPTH instruction/PC pairs, reports count/full/empty, and keeps a
// sticky overflow flag for pushes attempted while full.
// Optional feature: define FETCH_DECODE_QUEUE_BYPASS_EN to let an empty queue
// pass the fetched instruction straight to decode in the same cycle.
module fetch_decode_queue #(
    parameter int  IWIDTH   = 32,
    parameter int  PC_WIDTH = 32,
    parameter int  DEPTH    = 4,
    localparam int CWIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                fq_clk,
    input  logic                fq_rst,
    input  logic                fq_i_ce,
    input  logic [IWIDTH-1:0]   fq_i_instr,
    input  logic [PC_WIDTH-1:0] fq_i_pc,
    output logic                fq_o_ready,
    input  logic                fq_i_stall,
    input  logic                fq_i_flush,
    output logic                fq_o_ce,
    output logic [IWIDTH-1:0]   fq_o_instr,
    output logic [PC_WIDTH-1:0] fq_o_pc,
    output logic [CWIDTH-1:0]   fq_o_count,
    output logic                fq_o_full,
    output logic                fq_o_empty,
    output logic                fq_o_overflow
);

    localparam int               AWIDTH  = $clog2(DEPTH);
    localparam logic [CWIDTH-1:0] DEPTH_C = CWIDTH'(DEPTH);

    logic [IWIDTH-1:0]   instr_mem_r [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem_r    [DEPTH];
    logic [AWIDTH-1:0]   wr_ptr_r;
    logic [AWIDTH-1:0]   rd_ptr_r;
    logic [CWIDTH-1:0]   count_r;
    logic                overflow_r;

    logic                empty_s;
    logic                full_s;
    logic                bypass_s;
    logic                push_s;
    logic                pop_s;

    assign empty_s       = (count_r == {CWIDTH{1'b0}});
    assign full_s        = (count_r == DEPTH_C);
    assign fq_o_empty    = empty_s;
    assign fq_o_full     = full_s;
    assign fq_o_ready    = ~full_s;
    assign fq_o_count    = count_r;
    assign fq_o_overflow = overflow_r;

    // Decide this cycle's push/pop; a flush or a bypassed instruction stores nothing.
    always_comb begin
        bypass_s = 1'b0;
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
        bypass_s = empty_s & fq_i_ce & ~fq_i_stall & ~fq_i_flush;
`endif
        push_s = fq_i_ce & ~full_s & ~bypass_s & ~fq_i_flush;
        pop_s  = ~empty_s & ~fq_i_stall & ~fq_i_flush;
    end

    // Pointer, occupancy and sticky overflow state; flush beats every other update.
    always_ff @(posedge fq_clk or posedge fq_rst) begin
        if (fq_rst) begin
            wr_ptr_r   <= {AWIDTH{1'b0}};
            rd_ptr_r   <= {AWIDTH{1'b0}};
            count_r    <= {CWIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else if (fq_i_flush) begin
            wr_ptr_r   <= {AWIDTH{1'b0}};
            rd_ptr_r   <= {AWIDTH{1'b0}};
            count_r    <= {CWIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AWIDTH'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AWIDTH'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CWIDTH'(1'b1);
                2'b01:   count_r <= count_r - CWIDTH'(1'b1);
                default: count_r <= count_r;
            endcase
            if (fq_i_ce & full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset here.
    always_ff @(posedge fq_clk) begin
        if (push_s) begin
            instr_mem_r[wr_ptr_r] <= fq_i_instr;
            pc_mem_r[wr_ptr_r]    <= fq_i_pc;
        end
    end

    // Head presentation toward decode; data is forced to zero when nothing is valid.
    always_comb begin
        fq_o_ce    = 1'b0;
        fq_o_instr = {IWIDTH{1'b0}};
        fq_o_pc    = {PC_WIDTH{1'b0}};
        if (!empty_s) begin
            fq_o_ce    = 1'b1;
            fq_o_instr = instr_mem_r[rd_ptr_r];
            fq_o_pc    = pc_mem_r[rd_ptr_r];
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
        end else if (bypass_s) begin
            fq_o_ce    = 1'b1;
            fq_o_instr = fq_i_instr;
            fq_o_pc    = fq_i_pc;
`endif
        end else begin
            fq_o_ce    = 1'b0;
            fq_o_instr = {IWIDTH{1'b0}};
            fq_o_pc    = {PC_WIDTH{1'b0}};
        end
    end

endmodule

// File: doc/fetch_decode_queue.md
FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 SHALL have parameter IWIDTH, default 32: instruction width in bits.
REQ-002 SHALL have parameter PC_WIDTH, default 32: PC width in bits.
REQ-003 SHALL have parameter DEPTH, default 4: entry count, power of two, >= 2; CWIDTH = $clog2(DEPTH)+1 is derived, not overridable.
REQ-004 SHALL have port fq_clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port fq_rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port fq_i_ce, input, 1: fetch presents a valid instruction.
REQ-007 SHALL have port fq_i_instr, input, IWIDTH: fetched instruction.
REQ-008 SHALL have port fq_i_pc, input, PC_WIDTH: PC of fq_i_instr.
REQ-009 SHALL have port fq_o_ready, output, 1: queue accepts a push this cycle.
REQ-010 SHALL have port fq_i_stall, input, 1: decode refuses the head entry this cycle.
REQ-011 SHALL have port fq_i_flush, input, 1: discard all entries.
REQ-012 SHALL have port fq_o_ce, output, 1: head entry valid toward decode.
REQ-013 SHALL have port fq_o_instr, output, IWIDTH: head instruction.
REQ-014 SHALL have port fq_o_pc, output, PC_WIDTH: head PC.
REQ-015 SHALL have port fq_o_count, output, CWIDTH: stored entry count, 0..DEPTH.
REQ-016 SHALL have port fq_o_full, output, 1: count == DEPTH.
REQ-017 SHALL have port fq_o_empty, output, 1: count == 0.
REQ-018 SHALL have port fq_o_overflow, output, 1: sticky flag, a push was attempted while full.

Function
REQ-019 SHALL define push = fq_i_ce & fq_o_ready and pop = fq_o_ce & ~fq_i_stall.
REQ-020 SHALL drive fq_o_ready = ~fq_o_full combinationally; no push while full, even if a pop occurs that cycle.
REQ-021 SHALL be first-word-fall-through: fq_o_ce = ~fq_o_empty; fq_o_instr/fq_o_pc show the entry at the read pointer.
REQ-022 SHALL drive fq_o_instr and fq_o_pc to 0 whenever fq_o_ce = 0.
REQ-023 SHALL, without bypass, make a pushed entry visible at fq_o_ce one cycle after the push edge.
REQ-024 SHALL write on push to the write pointer and advance it; SHALL advance the read pointer on pop; both wrap DEPTH-1 -> 0.
REQ-025 SHALL update count by +1 for push only, -1 for pop only, and 0 for simultaneous push and pop.
REQ-026 SHALL preserve FIFO order; fq_o_pc SHALL stay paired with its fq_o_instr.
REQ-027 SHALL hold head outputs stable while fq_i_stall = 1 and fq_o_ce = 1.
REQ-028 SHALL, on fq_i_flush = 1, zero both pointers and count at the next edge; any push or pop that cycle is ignored.
REQ-029 SHALL set fq_o_overflow when fq_i_ce = 1 and fq_o_full = 1; the push is dropped.
REQ-030 SHALL clear fq_o_overflow only by flush or reset; if flush and the overflow condition coincide, flush wins and the flag is 0.

Reset
REQ-031 SHALL, while fq_rst = 1, immediately force: count 0, pointers 0, fq_o_ce 0, fq_o_instr 0, fq_o_pc 0, fq_o_empty 1, fq_o_full 0, fq_o_ready 1, fq_o_overflow 0.
REQ-032 SHALL let reset abort any in-flight operation; storage contents need not be cleared.

Configuration
REQ-033 SHALL compile an empty-queue bypass when macro FETCH_DECODE_QUEUE_BYPASS_EN is defined: if empty, fq_i_ce = 1, fq_i_stall = 0 and no flush, input passes combinationally to outputs with fq_o_ce = 1 in the same cycle, and nothing is stored (count stays 0).
REQ-034 SHALL, when the macro is undefined, use REQ-023 latency with no combinational path from fq_i_* to fq_o_ce/fq_o_instr/fq_o_pc.

Verification (DEPTH=4)
REQ-035 SHALL check: push 0x00000013@pc 0x0, then 0x00100093@pc 0x4, no stall -> decode sees them in order, each one cycle after its push (same cycle with bypass), count returns to 0.
REQ-036 SHALL check: stall held, 4 pushes -> count 4, full 1, ready 0; 5th fq_i_ce -> overflow 1, entry dropped; release stall -> exactly the 4 entries emerge in order.
REQ-037 SHALL check: count 2 with simultaneous push and pop for 6 cycles -> count stays 2, pointers wrap, order preserved.
REQ-038 SHALL check: count 3 with overflow 1, assert flush together with a push -> next cycle count 0, empty 1, fq_o_ce 0, overflow 0, pushed entry absent.
REQ-039 SHALL check: fq_rst asserted mid-stream between clock edges -> outputs reach reset values before the next edge; after release, first push at pc 0x100 emerges correctly.
